// File: rtl/axioma_pkg.sv
// Shared definitions for the AxiomaCore-328 power-management controller:
// FSM state encodings, SMCR sleep-mode codes, register addresses and the
// CLKPR/WDTCSR bit positions, plus small helpers that classify sleep modes.
package axioma_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_SLEEP      = 2'd1,
    ST_WAKE_DELAY = 2'd2
  } pwr_state_e;

  // SMCR.SM sleep-mode codes
  localparam logic [2:0] SLEEP_IDLE         = 3'b000;
  localparam logic [2:0] SLEEP_ADC_NOISE    = 3'b001;
  localparam logic [2:0] SLEEP_POWER_DOWN   = 3'b010;
  localparam logic [2:0] SLEEP_POWER_SAVE   = 3'b011;
  localparam logic [2:0] SLEEP_RESERVED_A   = 3'b100;
  localparam logic [2:0] SLEEP_RESERVED_B   = 3'b101;
  localparam logic [2:0] SLEEP_STANDBY      = 3'b110;
  localparam logic [2:0] SLEEP_EXT_STANDBY  = 3'b111;

  // Register addresses
  localparam logic [1:0] ADDR_CLKPR    = 2'd0;
  localparam logic [1:0] ADDR_SMCR     = 2'd1;
  localparam logic [1:0] ADDR_WDTCSR   = 2'd2;
  localparam logic [1:0] ADDR_RESERVED = 2'd3;

  // CLKPR fields
  localparam int         CLKPCE_BIT    = 7;
  localparam logic [7:0] CLKPR_CHANGE  = 8'h80;
  localparam logic [3:0] CLKPS_MAX     = 4'h8;

  // WDTCSR fields
  localparam int WDP3_BIT = 5;
  localparam int WDCE_BIT = 4;
  localparam int WDE_BIT  = 3;

  // Modes 100/101 are undefined on the ATmega328P and must not enter sleep
  function automatic logic is_reserved_mode(input logic [2:0] sm);
    return (sm == SLEEP_RESERVED_A) || (sm == SLEEP_RESERVED_B);
  endfunction

  // Idle and ADC-noise modes keep the clocks running: any interrupt wakes, no delay
  function automatic logic is_idle_class(input logic [2:0] sm);
    return (sm == SLEEP_IDLE) || (sm == SLEEP_ADC_NOISE);
  endfunction

  // Standby modes keep the oscillator alive, so they use the short delay
  function automatic logic is_standby_class(input logic [2:0] sm);
    return (sm == SLEEP_STANDBY) || (sm == SLEEP_EXT_STANDBY);
  endfunction

endpackage

// File: rtl/axioma_timed_window.sv
// Change-enable window counter. An open request (re)starts a window that
// stays open for WINDOW cycles; a close request shuts it early. Used for the
// CLKPR and WDTCSR timed-write sequences.
module axioma_timed_window #(
  parameter int WINDOW = 4
) (
  input  logic clk_ext,
  input  logic power_on_reset_n,
  input  logic open_req,
  input  logic close_req,
  output logic is_open
);

  localparam int CW = $clog2(WINDOW + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Restart has priority over close; otherwise count down to zero
  always_comb begin
    count_d = count_q;
    if (open_req) begin
      count_d = CW'(WINDOW);
    end else if (close_req) begin
      count_d = '0;
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  // Window counter register
  always_ff @(posedge clk_ext or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign is_open = (count_q != '0);

endmodule

// File: rtl/axioma_power_ctrl.sv
// AxiomaCore-328 power-management controller: CLKPR/SMCR/WDTCSR registers with
// timed-write protection, sleep/wake sequencing with start-up delay, and the
// clock-system configuration outputs.
// Build option AXIOMA_PWR_WDT_EN: when defined, the WDTCSR register and its
// timed sequence are present; otherwise the watchdog outputs are tied to 0.
module axioma_power_ctrl
  import axioma_pkg::*;
#(
  parameter int STARTUP_CYCLES = 16,
  parameter int STANDBY_CYCLES = 6,
  parameter int TIMED_WINDOW   = 4
) (
  input  logic       clk_ext,
  input  logic       power_on_reset_n,
  input  logic [3:0] fuse_cksel,
  input  logic       reg_we,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  input  logic       sleep_req,
  input  logic       wake_irq,
  input  logic       wake_async,
  output logic [3:0] clock_select,
  output logic [3:0] clock_prescaler,
  output logic       sleep_enable,
  output logic [2:0] sleep_mode,
  output logic       wdt_enable,
  output logic [3:0] wdt_prescaler,
  output logic       cpu_halt,
  output logic       wake_ack,
  output logic [1:0] state_dbg
);

  localparam int MAX_DLY = (STARTUP_CYCLES > STANDBY_CYCLES) ? STARTUP_CYCLES : STANDBY_CYCLES;
  localparam int CNT_W   = $clog2(MAX_DLY + 1);

  pwr_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sleep_enable_q, cpu_halt_q, wake_ack_q, wake_ack_d;
  logic [3:0] clock_select_q, clock_select_d;
  logic sampled_q, sampled_d;
  logic [3:0] clkps_q, clkps_d;
  logic [2:0] sm_q, sm_d;
  logic se_q, se_d;
  logic clk_open, clk_close, clk_win;
  logic we_ok, wr_clkpr, wr_smcr;
  logic wake_cond;
  logic [7:0] wdtcsr_rdata;
  logic unused_wdata;

  assign unused_wdata = ^reg_wdata[6:4];

  // Software writes are only accepted while the CPU is running
  assign we_ok    = reg_we & ~cpu_halt_q;
  assign wr_clkpr = we_ok && (reg_addr == ADDR_CLKPR);
  assign wr_smcr  = we_ok && (reg_addr == ADDR_SMCR);

  axioma_timed_window #(.WINDOW(TIMED_WINDOW)) u_clkpr_window (
    .clk_ext          (clk_ext),
    .power_on_reset_n (power_on_reset_n),
    .open_req         (clk_open),
    .close_req        (clk_close),
    .is_open          (clk_win)
  );

  // Clock-source fuse is captured once, on the first cycle out of reset
  always_comb begin
    clock_select_d = clock_select_q;
    sampled_d      = 1'b1;
    if (!sampled_q) begin
      clock_select_d = fuse_cksel;
    end
  end

  // CLKPR timed write: 0x80 opens, a bit7=0 write inside the window loads and closes
  always_comb begin
    clkps_d   = clkps_q;
    clk_open  = 1'b0;
    clk_close = 1'b0;
    if (wr_clkpr) begin
      if (reg_wdata == CLKPR_CHANGE) begin
        clk_open = 1'b1;
      end else if (!reg_wdata[CLKPCE_BIT] && clk_win) begin
        clk_close = 1'b1;
        if (reg_wdata[3:0] <= CLKPS_MAX) begin
          clkps_d = reg_wdata[3:0];
        end
      end
    end
  end

  // SMCR is a plain register
  always_comb begin
    sm_d = sm_q;
    se_d = se_q;
    if (wr_smcr) begin
      sm_d = reg_wdata[3:1];
      se_d = reg_wdata[0];
    end
  end

  // Register file and fuse capture
  always_ff @(posedge clk_ext or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      clock_select_q <= 4'h0;
      sampled_q      <= 1'b0;
      clkps_q        <= 4'h0;
      sm_q           <= 3'b000;
      se_q           <= 1'b0;
    end else begin
      clock_select_q <= clock_select_d;
      sampled_q      <= sampled_d;
      clkps_q        <= clkps_d;
      sm_q           <= sm_d;
      se_q           <= se_d;
    end
  end

`ifdef AXIOMA_PWR_WDT_EN
  logic wr_wdtcsr;
  logic wde_q, wde_d;
  logic [3:0] wdp_q, wdp_d;
  logic wdt_open, wdt_close, wdt_win;

  assign wr_wdtcsr = we_ok && (reg_addr == ADDR_WDTCSR);

  axioma_timed_window #(.WINDOW(TIMED_WINDOW)) u_wdtcsr_window (
    .clk_ext          (clk_ext),
    .power_on_reset_n (power_on_reset_n),
    .open_req         (wdt_open),
    .close_req        (wdt_close),
    .is_open          (wdt_win)
  );

  // WDTCSR: in-window load, WDCE+WDE opens, WDE may always be set 0->1
  always_comb begin
    wde_d     = wde_q;
    wdp_d     = wdp_q;
    wdt_open  = 1'b0;
    wdt_close = 1'b0;
    if (wr_wdtcsr) begin
      if (wdt_win && !reg_wdata[WDCE_BIT]) begin
        wde_d     = reg_wdata[WDE_BIT];
        wdp_d     = {reg_wdata[WDP3_BIT], reg_wdata[2:0]};
        wdt_close = 1'b1;
      end else if (reg_wdata[WDCE_BIT] && reg_wdata[WDE_BIT]) begin
        wdt_open = 1'b1;
      end else if (!wde_q && reg_wdata[WDE_BIT] && !reg_wdata[WDCE_BIT]) begin
        wde_d = 1'b1;
      end
    end
  end

  // Watchdog configuration register
  always_ff @(posedge clk_ext or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      wde_q <= 1'b0;
      wdp_q <= 4'h0;
    end else begin
      wde_q <= wde_d;
      wdp_q <= wdp_d;
    end
  end

  assign wdtcsr_rdata  = {2'b00, wdp_q[3], wdt_win, wde_q, wdp_q[2:0]};
  assign wdt_enable    = wde_q;
  assign wdt_prescaler = wdp_q;
`else
  assign wdtcsr_rdata  = 8'h00;
  assign wdt_enable    = 1'b0;
  assign wdt_prescaler = 4'h0;
`endif

  // Mode-dependent wake qualification: deep modes ignore synchronous interrupts
  assign wake_cond = is_idle_class(sm_q) ? (wake_irq | wake_async) : wake_async;

  // Sleep/wake sequencing next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (sleep_req && se_q && !is_reserved_mode(sm_q)) begin
          state_d = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (wake_cond) begin
          if (is_idle_class(sm_q)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_WAKE_DELAY;
            cnt_d   = is_standby_class(sm_q) ? CNT_W'(STANDBY_CYCLES) : CNT_W'(STARTUP_CYCLES);
          end
        end
      end
      ST_WAKE_DELAY: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    wake_ack_d = (state_q != ST_RUN) && (state_d == ST_RUN);
  end

  // FSM state and its registered outputs
  always_ff @(posedge clk_ext or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      state_q        <= ST_RUN;
      cnt_q          <= '0;
      sleep_enable_q <= 1'b0;
      cpu_halt_q     <= 1'b0;
      wake_ack_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sleep_enable_q <= (state_d == ST_SLEEP);
      cpu_halt_q     <= (state_d != ST_RUN);
      wake_ack_q     <= wake_ack_d;
    end
  end

  // Combinational register read port
  always_comb begin
    reg_rdata = 8'h00;
    unique case (reg_addr)
      ADDR_CLKPR:    reg_rdata = {4'h0, clkps_q};
      ADDR_SMCR:     reg_rdata = {4'h0, sm_q, se_q};
      ADDR_WDTCSR:   reg_rdata = wdtcsr_rdata;
      ADDR_RESERVED: reg_rdata = 8'h00;
      default:       reg_rdata = 8'h00;
    endcase
  end

  assign clock_select    = clock_select_q;
  assign clock_prescaler = clkps_q;
  assign sleep_enable    = sleep_enable_q;
  assign sleep_mode      = sm_q;
  assign cpu_halt        = cpu_halt_q;
  assign wake_ack        = wake_ack_q;
  assign state_dbg       = state_q;

endmodule
